// File: rtl/dram_app_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dram_app_arbiter                                           |
// | Description : Two-requester round-robin arbiter and sequencer in front   |
// |               of the DDR3 MIG user (app_*) interface. Each write is sent |
// |               as two write-data beats followed by one command. In-order  |
// |               read returns are steered back to the requester that issued |
// |               the read, using a small tag FIFO.                          |
// |                                                                          |
// | Ports       : tb_clk, tb_rst_n      clock, async active-low reset        |
// |               phy_init_done         MIG calibration complete             |
// |               a_* / b_*             requester command, write-data and    |
// |                                     read-valid channels                  |
// |               rd_data, rd_last      shared read-return data              |
// |               app_*, tg_addr        MIG command / write FIFO / read port |
// |               rd_err                sticky: read beat with no tag        |
// |               busy                  transaction active or reads pending  |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dram_app_arbiter #(
   parameter int ADDR_WIDTH    = 27,
   parameter int PAYLOAD_WIDTH = 64,
   parameter int TAG_DEPTH     = 8,
   parameter int TAG_AW        = 3
) (
   input  logic                            tb_clk,
   input  logic                            tb_rst_n,
   input  logic                            phy_init_done,
   // requester A
   input  logic                            a_cmd_valid,
   output logic                            a_cmd_ready,
   input  logic                            a_cmd_write,
   input  logic [ADDR_WIDTH-1:0]           a_cmd_addr,
   input  logic                            a_wd_valid,
   output logic                            a_wd_ready,
   input  logic [4*PAYLOAD_WIDTH-1:0]      a_wd_data,
   input  logic [4*PAYLOAD_WIDTH/8-1:0]    a_wd_mask,
   output logic                            a_rd_valid,
   // requester B
   input  logic                            b_cmd_valid,
   output logic                            b_cmd_ready,
   input  logic                            b_cmd_write,
   input  logic [ADDR_WIDTH-1:0]           b_cmd_addr,
   input  logic                            b_wd_valid,
   output logic                            b_wd_ready,
   input  logic [4*PAYLOAD_WIDTH-1:0]      b_wd_data,
   input  logic [4*PAYLOAD_WIDTH/8-1:0]    b_wd_mask,
   output logic                            b_rd_valid,
   // shared read return
   output logic [4*PAYLOAD_WIDTH-1:0]      rd_data,
   output logic                            rd_last,
   // MIG command channel
   output logic                            app_en,
   output logic [2:0]                      app_cmd,
   output logic [ADDR_WIDTH-1:0]           tg_addr,
   input  logic                            app_full,
   // MIG write-data channel
   output logic                            app_wdf_wren,
   output logic [4*PAYLOAD_WIDTH-1:0]      app_wdf_data,
   output logic [4*PAYLOAD_WIDTH/8-1:0]    app_wdf_mask,
   output logic                            app_wdf_end,
   input  logic                            app_wdf_full,
   // MIG read-data channel
   input  logic [4*PAYLOAD_WIDTH-1:0]      app_rd_data,
   input  logic                            app_rd_data_valid,
   input  logic                            app_rd_data_end,
   // status
   output logic                            rd_err,
   output logic                            busy
);

   localparam logic [TAG_AW:0] c_TAG_FULL = (TAG_AW+1)'(TAG_DEPTH);
   localparam logic [2:0]      c_CMD_WR   = 3'b000;
   localparam logic [2:0]      c_CMD_RD   = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WD0  = 2'd1,
      ST_WD1  = 2'd2,
      ST_CMD  = 2'd3
   } state_t;

   state_t                  r_state;
   logic                    r_grant;      // 0 = A, 1 = B
   logic                    r_prio;       // requester preferred on a tie
   logic [TAG_DEPTH-1:0]    r_tag_mem;    // requester id per outstanding read
   logic [TAG_AW-1:0]       r_wr_ptr;
   logic [TAG_AW-1:0]       r_rd_ptr;
   logic [TAG_AW:0]         r_count;
   logic                    r_rd_err;

   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic                    w_a_elig;
   logic                    w_b_elig;
   logic                    w_pick;
   logic                    w_pick_write;
   logic                    w_g_write;
   logic [ADDR_WIDTH-1:0]   w_g_addr;
   logic                    w_g_wd_valid;
   logic                    w_in_wd;
   logic                    w_wren;
   logic                    w_cmd_done;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_rd_hit;
   logic                    w_head;

   assign w_fifo_full  = (r_count == c_TAG_FULL);
   assign w_fifo_empty = (r_count == '0);

   // A read may only be granted when its tag is guaranteed a FIFO slot.
   assign w_a_elig = a_cmd_valid & phy_init_done & (a_cmd_write | ~w_fifo_full);
   assign w_b_elig = b_cmd_valid & phy_init_done & (b_cmd_write | ~w_fifo_full);
   assign w_pick   = (w_a_elig & w_b_elig) ? r_prio : w_b_elig;
   assign w_pick_write = w_pick ? b_cmd_write : a_cmd_write;

   // Granted-requester muxes
   assign w_g_write    = r_grant ? b_cmd_write : a_cmd_write;
   assign w_g_addr     = r_grant ? b_cmd_addr  : a_cmd_addr;
   assign w_g_wd_valid = r_grant ? b_wd_valid  : a_wd_valid;

   assign w_in_wd    = (r_state == ST_WD0) | (r_state == ST_WD1);
   assign w_wren     = w_in_wd & w_g_wd_valid & ~app_wdf_full;
   assign w_cmd_done = (r_state == ST_CMD) & ~app_full;
   assign w_push     = w_cmd_done & ~w_g_write;
   assign w_pop      = app_rd_data_valid & app_rd_data_end & ~w_fifo_empty;

   assign w_head     = r_tag_mem[r_rd_ptr];
   assign w_rd_hit   = app_rd_data_valid & ~w_fifo_empty;

   // Command channel
   assign app_en      = (r_state == ST_CMD);
   assign app_cmd     = (r_state == ST_CMD) ? (w_g_write ? c_CMD_WR : c_CMD_RD) : 3'b000;
   assign tg_addr     = (r_state == ST_CMD) ? w_g_addr : '0;
   assign a_cmd_ready = w_cmd_done & ~r_grant;
   assign b_cmd_ready = w_cmd_done &  r_grant;

   // Write-data channel
   assign a_wd_ready   = w_in_wd & ~r_grant & ~app_wdf_full;
   assign b_wd_ready   = w_in_wd &  r_grant & ~app_wdf_full;
   assign app_wdf_wren = w_wren;
   assign app_wdf_end  = w_wren & (r_state == ST_WD1);
   assign app_wdf_data = r_grant ? b_wd_data : a_wd_data;
   assign app_wdf_mask = r_grant ? b_wd_mask : a_wd_mask;

   // Read return: beats with no outstanding tag are dropped
   assign a_rd_valid = w_rd_hit & ~w_head;
   assign b_rd_valid = w_rd_hit &  w_head;
   assign rd_data    = app_rd_data;
   assign rd_last    = app_rd_data_end;

   assign rd_err = r_rd_err;
   assign busy   = (r_state != ST_IDLE) | ~w_fifo_empty;

   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         r_state   <= ST_IDLE;
         r_grant   <= 1'b0;
         r_prio    <= 1'b0;
         r_tag_mem <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rd_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_a_elig | w_b_elig) begin
                  r_grant <= w_pick;
                  r_state <= w_pick_write ? ST_WD0 : ST_CMD;
               end
            end
            ST_WD0: begin
               if (w_wren) r_state <= ST_WD1;
            end
            ST_WD1: begin
               if (w_wren) r_state <= ST_CMD;
            end
            ST_CMD: begin
               if (!app_full) begin
                  r_prio  <= ~r_grant;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_grant;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (app_rd_data_valid && w_fifo_empty) begin
            r_rd_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_app_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dram_app_arbiter                                        |
// | Description : Self-checking bench for dram_app_arbiter. A per-cycle      |
// |               vector table covers arbitration, write sequencing, stalls  |
// |               and phy gating; directed sequences cover read steering,    |
// |               tag-FIFO full blocking, rd_err and mid-write reset.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_dram_app_arbiter;

   localparam int AW = 27;
   localparam int DW = 256;
   localparam int MW = 32;
   localparam bit H  = 1'b1;
   localparam bit L  = 1'b0;
   localparam int NV = 24;

   logic           tb_clk = 1'b0;
   logic           tb_rst_n = 1'b1;
   logic           phy_init_done;
   logic           a_cmd_valid, a_cmd_ready, a_cmd_write, a_wd_valid, a_wd_ready, a_rd_valid;
   logic [AW-1:0]  a_cmd_addr;
   logic [DW-1:0]  a_wd_data;
   logic [MW-1:0]  a_wd_mask;
   logic           b_cmd_valid, b_cmd_ready, b_cmd_write, b_wd_valid, b_wd_ready, b_rd_valid;
   logic [AW-1:0]  b_cmd_addr;
   logic [DW-1:0]  b_wd_data;
   logic [MW-1:0]  b_wd_mask;
   logic [DW-1:0]  rd_data;
   logic           rd_last;
   logic           app_en;
   logic [2:0]     app_cmd;
   logic [AW-1:0]  tg_addr;
   logic           app_full;
   logic           app_wdf_wren;
   logic [DW-1:0]  app_wdf_data;
   logic [MW-1:0]  app_wdf_mask;
   logic           app_wdf_end;
   logic           app_wdf_full;
   logic [DW-1:0]  app_rd_data;
   logic           app_rd_data_valid;
   logic           app_rd_data_end;
   logic           rd_err;
   logic           busy;

   int nvec = 0;
   int nmis = 0;
   int a_rdy_cnt = 0;

   always #5 tb_clk = ~tb_clk;

   always @(negedge tb_clk) begin
      if (a_cmd_ready === 1'b1) a_rdy_cnt <= a_rdy_cnt + 1;
   end

   dram_app_arbiter dut (
      .tb_clk            (tb_clk),
      .tb_rst_n          (tb_rst_n),
      .phy_init_done     (phy_init_done),
      .a_cmd_valid       (a_cmd_valid),
      .a_cmd_ready       (a_cmd_ready),
      .a_cmd_write       (a_cmd_write),
      .a_cmd_addr        (a_cmd_addr),
      .a_wd_valid        (a_wd_valid),
      .a_wd_ready        (a_wd_ready),
      .a_wd_data         (a_wd_data),
      .a_wd_mask         (a_wd_mask),
      .a_rd_valid        (a_rd_valid),
      .b_cmd_valid       (b_cmd_valid),
      .b_cmd_ready       (b_cmd_ready),
      .b_cmd_write       (b_cmd_write),
      .b_cmd_addr        (b_cmd_addr),
      .b_wd_valid        (b_wd_valid),
      .b_wd_ready        (b_wd_ready),
      .b_wd_data         (b_wd_data),
      .b_wd_mask         (b_wd_mask),
      .b_rd_valid        (b_rd_valid),
      .rd_data           (rd_data),
      .rd_last           (rd_last),
      .app_en            (app_en),
      .app_cmd           (app_cmd),
      .tg_addr           (tg_addr),
      .app_full          (app_full),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_data      (app_wdf_data),
      .app_wdf_mask      (app_wdf_mask),
      .app_wdf_end       (app_wdf_end),
      .app_wdf_full      (app_wdf_full),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .app_rd_data_end   (app_rd_data_end),
      .rd_err            (rd_err),
      .busy              (busy)
   );

   typedef struct {
      bit            phy, av, aw;
      logic [AW-1:0] aaddr;
      bit            bv, bw;
      logic [AW-1:0] baddr;
      bit            awdv;
      logic [7:0]    dat;
      bit            full, wfull;
      bit            e_en;
      logic [2:0]    e_cmd;
      logic [AW-1:0] e_addr;
      bit            e_ar, e_br, e_wren, e_end, e_awr, e_bwr;
      logic [7:0]    e_dat;
   } vec_t;

   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      phy_init_done = v.phy;
      a_cmd_valid   = v.av;
      a_cmd_write   = v.aw;
      a_cmd_addr    = v.aaddr;
      b_cmd_valid   = v.bv;
      b_cmd_write   = v.bw;
      b_cmd_addr    = v.baddr;
      a_wd_valid    = v.awdv;
      b_wd_valid    = 1'b0;
      a_wd_data     = {32{v.dat}};
      a_wd_mask     = {32{v.dat[0]}};
      b_wd_data     = {32{~v.dat}};
      b_wd_mask     = {32{~v.dat[0]}};
      app_full      = v.full;
      app_wdf_full  = v.wfull;
   endtask

   task automatic clear_req();
      a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_wd_valid = 1'b0;
      b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_wd_valid = 1'b0;
      app_full = 1'b0; app_wdf_full = 1'b0;
   endtask

   // Wait (bounded) for the selected requester's cmd_ready; leaves time at posedge+1.
   task automatic wait_ready(input logic sel, input logic [AW-1:0] addr, input string name);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge tb_clk);
         if ((sel ? b_cmd_ready : a_cmd_ready) === 1'b1) begin
            seen = 1'b1;
            chk(name, 64'({1'b1, app_en, tg_addr}), 64'({1'b1, 1'b1, addr}));
         end
         @(posedge tb_clk); #1;
      end
      if (!seen) chk(name, 64'({seen, app_en, tg_addr}), 64'({1'b1, 1'b1, addr}));
   endtask

   task automatic issue(input logic sel, input logic wr, input logic [AW-1:0] addr, input string name);
      if (sel) begin
         b_cmd_valid = 1'b1; b_cmd_write = wr; b_cmd_addr = addr; b_wd_valid = wr;
      end else begin
         a_cmd_valid = 1'b1; a_cmd_write = wr; a_cmd_addr = addr; a_wd_valid = wr;
      end
      wait_ready(sel, addr, name);
      if (sel) begin b_cmd_valid = 1'b0; b_wd_valid = 1'b0; end
      else     begin a_cmd_valid = 1'b0; a_wd_valid = 1'b0; end
   endtask

   // One read-return beat; checks steering, last flag and data passthrough.
   task automatic ret(input logic last, input logic exp_b, input string name);
      app_rd_data_valid = 1'b1;
      app_rd_data_end   = last;
      app_rd_data       = {8{$urandom}};
      @(negedge tb_clk);
      chk(name, 64'({a_rd_valid, b_rd_valid, rd_last, rd_data == app_rd_data}),
                64'({~exp_b, exp_b, last, 1'b1}));
      @(posedge tb_clk); #1;
      app_rd_data_valid = 1'b0;
      app_rd_data_end   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", nmis);
      $fatal(1);
   end

   initial begin
      logic [45:0] act, exp;
      logic        tags_b [5];
      int          snap;

      //           phy av aw aaddr    bv bw baddr    awdv dat   full wfull | en cmd  addr     ar br wren end awr bwr dat
      vecs[0]  = '{L, H, L, 27'h055, L, L, 27'h000, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[1]  = '{L, H, L, 27'h055, L, L, 27'h000, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[2]  = '{H, H, L, 27'h055, L, L, 27'h000, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[3]  = '{H, H, L, 27'h055, L, L, 27'h000, L, 8'h00, L, L,  H, 3'd1, 27'h055, H, L, L, L, L, L, 8'h00};
      vecs[4]  = '{H, L, L, 27'h000, L, L, 27'h000, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[5]  = '{H, H, H, 27'h100, L, L, 27'h000, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[6]  = '{H, H, H, 27'h100, L, L, 27'h000, H, 8'h11, L, H,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[7]  = '{L, H, H, 27'h100, L, L, 27'h000, H, 8'h11, L, L,  L, 3'd0, 27'h000, L, L, H, L, H, L, 8'h11};
      vecs[8]  = '{L, H, H, 27'h100, L, L, 27'h000, H, 8'h22, L, L,  L, 3'd0, 27'h000, L, L, H, H, H, L, 8'h22};
      vecs[9]  = '{L, H, H, 27'h100, L, L, 27'h000, L, 8'h00, L, L,  H, 3'd0, 27'h100, H, L, L, L, L, L, 8'h00};
      vecs[10] = '{L, L, L, 27'h000, H, L, 27'h0B0, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[11] = '{L, L, L, 27'h000, H, L, 27'h0B0, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[12] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[13] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  H, 3'd1, 27'h0B0, L, H, L, L, L, L, 8'h00};
      vecs[14] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[15] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, H, L,  H, 3'd1, 27'h0A0, L, L, L, L, L, L, 8'h00};
      vecs[16] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, H, L,  H, 3'd1, 27'h0A0, L, L, L, L, L, L, 8'h00};
      vecs[17] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, H, L,  H, 3'd1, 27'h0A0, L, L, L, L, L, L, 8'h00};
      vecs[18] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  H, 3'd1, 27'h0A0, H, L, L, L, L, L, 8'h00};
      vecs[19] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[20] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  H, 3'd1, 27'h0B0, L, H, L, L, L, L, 8'h00};
      vecs[21] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};
      vecs[22] = '{H, H, L, 27'h0A0, H, L, 27'h0B0, L, 8'h00, L, L,  H, 3'd1, 27'h0A0, H, L, L, L, L, L, 8'h00};
      vecs[23] = '{H, L, L, 27'h000, L, L, 27'h000, L, 8'h00, L, L,  L, 3'd0, 27'h000, L, L, L, L, L, L, 8'h00};

      // Reads granted in the table: A, B, A, B, A
      tags_b[0] = 1'b0; tags_b[1] = 1'b1; tags_b[2] = 1'b0; tags_b[3] = 1'b1; tags_b[4] = 1'b0;

      // ---------------- reset ----------------
      apply(vecs[0]);
      app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
      #1 tb_rst_n = 1'b0;
      #6;
      chk("reset_outputs",
          64'({app_en, app_wdf_wren, app_wdf_end, a_cmd_ready, b_cmd_ready, a_wd_ready, b_wd_ready,
               a_rd_valid, b_rd_valid, app_cmd, tg_addr, rd_err, busy}), 64'(0));
      @(negedge tb_clk) tb_rst_n = 1'b1;
      @(posedge tb_clk); #1;

      // ---------------- vector table ----------------
      for (int i = 0; i < NV; i++) begin
         apply(vecs[i]);
         @(negedge tb_clk);
         act = {app_en, app_cmd, tg_addr, a_cmd_ready, b_cmd_ready, app_wdf_wren, app_wdf_end,
                a_wd_ready, b_wd_ready, (vecs[i].e_wren ? {app_wdf_mask[0], app_wdf_data[7:0]} : 9'h0)};
         exp = {vecs[i].e_en, vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_ar, vecs[i].e_br,
                vecs[i].e_wren, vecs[i].e_end, vecs[i].e_awr, vecs[i].e_bwr,
                (vecs[i].e_wren ? {vecs[i].e_dat[0], vecs[i].e_dat} : 9'h0)};
         nvec++;
         if (act !== exp) begin
            nmis++;
            $display("FAIL vec%0d: got %h expected %h", i, act, exp);
         end
         @(posedge tb_clk); #1;
      end
      clear_req();

      // ---------------- in-order read steering (A,B,A,B,A) ----------------
      for (int k = 0; k < 5; k++) begin
         ret(1'b0, tags_b[k], $sformatf("ret%0d_beat0", k));
         ret(1'b1, tags_b[k], $sformatf("ret%0d_beat1", k));
      end
      @(negedge tb_clk);
      chk("drained_not_busy", 64'(busy), 64'(0));
      @(posedge tb_clk); #1;

      // ---------------- tag FIFO full ----------------
      for (int k = 0; k < 8; k++) issue(1'b0, 1'b0, AW'(27'h200 + k), $sformatf("a_read%0d", k));
      @(negedge tb_clk);
      chk("busy_with_8_reads", 64'(busy), 64'(1));
      @(posedge tb_clk); #1;
      a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 27'h009;
      snap = a_rdy_cnt;
      issue(1'b1, 1'b1, 27'h077, "b_write_while_full");
      repeat (4) @(posedge tb_clk);
      #1;
      chk("a_read9_blocked", 64'(a_rdy_cnt), 64'(snap));
      ret(1'b0, 1'b0, "full_ret_beat0");
      ret(1'b1, 1'b0, "full_ret_beat1");
      wait_ready(1'b0, 27'h009, "a_read9_issued");
      a_cmd_valid = 1'b0;
      for (int k = 0; k < 8; k++) ret(1'b1, 1'b0, $sformatf("drain%0d", k));
      @(negedge tb_clk);
      chk("fifo_empty_after_drain", 64'({busy, rd_err}), 64'(0));
      @(posedge tb_clk); #1;

      // ---------------- spurious read data ----------------
      app_rd_data_valid = 1'b1; app_rd_data_end = 1'b0;
      @(negedge tb_clk);
      chk("spurious_no_rd_valid", 64'({a_rd_valid, b_rd_valid}), 64'(0));
      @(posedge tb_clk); #1;
      app_rd_data_valid = 1'b0;
      @(negedge tb_clk);
      chk("rd_err_set", 64'(rd_err), 64'(1));
      repeat (3) @(posedge tb_clk);
      @(negedge tb_clk);
      chk("rd_err_sticky", 64'(rd_err), 64'(1));
      @(posedge tb_clk); #1;

      // ---------------- reset during WD1 ----------------
      b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 27'h033; b_wd_valid = 1'b1;
      @(posedge tb_clk); #1;
      @(posedge tb_clk); #1;
      @(negedge tb_clk);
      chk("wd1_reached", 64'({app_wdf_wren, app_wdf_end, b_wd_ready}), 64'(3'b111));
      #1 tb_rst_n = 1'b0;
      #1;
      chk("reset_mid_wd1",
          64'({app_en, app_wdf_wren, app_wdf_end, a_cmd_ready, b_cmd_ready, a_wd_ready, b_wd_ready,
               a_rd_valid, b_rd_valid, app_cmd, tg_addr, rd_err, busy}), 64'(0));
      clear_req();
      @(negedge tb_clk) tb_rst_n = 1'b1;
      snap = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge tb_clk);
         if (app_en === 1'b1 || busy === 1'b1) snap++;
      end
      chk("idle_after_reset", 64'(snap), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
`default_nettype wire
